keypad_event_scanner: RTL
=========================

Name: keypad_event_scanner

Overview:
Upstream of the AHB keyboard peripheral. Drives a 4x4 active-low key matrix and samples its columns. Debounces whole-matrix frames and turns committed key-state changes into press/release events. Events are queued in a small show-ahead FIFO that the bus slave pops; it also provides the interrupt level.

Parameters:
SCAN_DIV, 50000, HCLK cycles each row is driven (1 ms at 50 MHz); must be >= 4
DEB_SCANS, 4, consecutive identical full frames required before a frame is committed; range 1..15
FIFO_DEPTH, 8, event FIFO entries; power of 2, range 2..32

Ports:
HCLK  input  1  single clock, rising edge
HRESET  input  1  reset, asynchronous, active-high
col  input  4  matrix columns, active-low, externally pulled up, asynchronous to HCLK
row  output  4  matrix rows, active-low; exactly one row low while scanning
evt_pop  input  1  consumer pops the FIFO head this cycle
evt_valid  output  1  FIFO not empty
evt_code  output  5  FIFO head: [4] 1=press/0=release, [3:0] key index = row*4+col; 5'h00 when empty
evt_count  output  6  FIFO occupancy, 0..FIFO_DEPTH
overflow  output  1  sticky flag: an event was dropped because the FIFO was full
ovf_clr  input  1  clears overflow
key_irq  output  1  registered copy of evt_valid

Behaviour:
- Reset values: row=4'hF; evt_valid=0; evt_code=0; evt_count=0; overflow=0; key_irq=0.
- Reset values of internal state: committed state=16'h0; candidate=16'h0; stable count=0; FSM=SCAN; row index=0; divider=0.
- col passes through a 2-flop synchronizer. The synchronized value is inverted, so 1 = pressed.
- SCAN state:
  - The row index r (0..3) holds for SCAN_DIV cycles; row=~(4'b1<<r).
  - On the last cycle of the slot, frame[r*4+:4] is loaded with the synchronized, inverted col. r then increments, wrapping 3->0.
  - The first slot after reset starts the cycle after HRESET deasserts.
- Frame complete (end of the r=3 slot):
  - If frame != candidate: candidate<=frame and stable count<=1.
  - Otherwise the stable count increments, saturating at DEB_SCANS.
  - When the stable count reaches DEB_SCANS and candidate != committed, the FSM enters EMIT. The row divider pauses and row holds its value.
- EMIT state: one event per cycle.
  - i = lowest set bit of (committed ^ candidate).
  - Push {candidate[i], i[3:0]} and set committed[i]<=candidate[i].
  - Return to SCAN on the cycle the diff becomes zero.
  - Multiple simultaneous changes are therefore emitted in ascending index order.
- FIFO:
  - Show-ahead: evt_code is the head combinationally from registered storage.
  - A pop with evt_valid=0 is ignored.
  - A push succeeds if count<FIFO_DEPTH, or if count==FIFO_DEPTH and evt_pop=1 in the same cycle (pop and push both occur).
  - A push into a full FIFO without a pop is dropped and overflow<=1. committed is still updated, so no duplicate event appears later.
  - Simultaneous push and pop with count between 1 and FIFO_DEPTH-1: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: when ovf_clr and a drop occur in the same cycle, set wins.
- key_irq: evt_valid delayed by one cycle.
- Reset mid-EMIT or mid-scan: everything returns to reset values. Events in flight are lost, and no release events are generated for keys held at reset.

Optional Feature:
KEYPAD_GHOST_REJECT_EN
- Defined: a completed frame with 3 or more pressed keys is discarded. candidate is unchanged, stable count<=0, and no events are produced. This suppresses phantom keys in a diode-less matrix.
- Not defined: every frame is processed as above.

Test Plan:
All scenarios use SCAN_DIV=4, DEB_SCANS=2, FIFO_DEPTH=4.
1. Reset, hold col=4'hF for 10 frames -> row cycles E,D,B,7, each for 4 cycles; evt_valid stays 0.
2. Press key 5 (col[1] low while row=4'hD) for 4 frames -> exactly one event 5'h15, key_irq=1 one cycle after evt_valid. Pop it; then release -> event 5'h05.
3. Bounce key 5 on alternate frames for 6 frames, then release -> no event, since no 2 consecutive identical frames.
4. Press keys 0 and 15 in the same frame -> events 5'h10 then 5'h1F on consecutive cycles, evt_count=2.
5. Generate 6 events with no pops -> evt_count=4 and overflow=1. Pops return the first 4 events in order. ovf_clr clears overflow. Pop plus push while full -> count stays 4.
6. With KEYPAD_GHOST_REJECT_EN, press keys 0, 1 and 4 together -> no events. Without the macro -> events 5'h10, 5'h11, 5'h14.

Source files
------------

// File: rtl/keypad_event_scanner.sv
// rtl/keypad_event_scanner.sv - 4x4 key matrix scanner with frame debounce and press/release event FIFO
// Optional build macro KEYPAD_GHOST_REJECT_EN discards frames showing 3 or more pressed keys.
module keypad_event_scanner #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_SCANS  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic [3:0] col,
  output logic [3:0] row,
  input  logic       evt_pop,
  output logic       evt_valid,
  output logic [4:0] evt_code,
  output logic [5:0] evt_count,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic       key_irq
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_MAX = 4'(DEB_SCANS);
  localparam logic [5:0] DEPTH = 6'(FIFO_DEPTH);

  typedef enum logic {SCAN, EMIT} state_t;
  state_t state, state_nxt;

  logic [3:0]    col_s1, col_s2;
  logic          run;
  logic [DW-1:0] div;
  logic [1:0]    r;
  logic [11:0]   frame;
  logic [15:0]   committed, candidate, frame_full, cand_nxt, diff;
  logic [3:0]    stable, stable_nxt, emit_idx;
  logic          frame_end, ghost, commit_go, emit_last;
  logic          push, pop_ok, push_ok, drop;
  logic [4:0]    push_code;
  logic [4:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      col_s1 <= 4'hF;
      col_s2 <= 4'hF;
    end else begin
      col_s1 <= col;
      col_s2 <= col_s1;
    end
  end

  // run holds rows released until the first cycle after reset, so slot 0 starts there
  assign row        = run ? ~(4'b0001 << r) : 4'hF;
  assign frame_end  = run && (state == SCAN) && (div == DIV_LAST) && (r == 2'd3);
  assign frame_full = {~col_s2, frame};

`ifdef KEYPAD_GHOST_REJECT_EN
  logic [4:0] pressed;
  always_comb begin
    pressed = '0;
    for (int k = 0; k < 16; k++) pressed = pressed + 5'(frame_full[k]);
  end
  assign ghost = (pressed >= 5'd3);
`else
  assign ghost = 1'b0;
`endif

  always_comb begin
    cand_nxt   = candidate;
    stable_nxt = stable;
    if (ghost) begin
      stable_nxt = '0;
    end else if (frame_full != candidate) begin
      cand_nxt   = frame_full;
      stable_nxt = 4'd1;
    end else if (stable != DEB_MAX) begin
      stable_nxt = stable + 4'd1;
    end
  end

  assign commit_go = frame_end && !ghost && (stable_nxt == DEB_MAX) && (cand_nxt != committed);

  // lowest differing key goes first, giving ascending-index event order
  assign diff = committed ^ candidate;
  always_comb begin
    emit_idx = 4'd0;
    for (int k = 15; k >= 0; k--) if (diff[k]) emit_idx = 4'(k);
  end
  assign emit_last = ((diff & (diff - 16'd1)) == 16'd0);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= SCAN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SCAN:    if (commit_go) state_nxt = EMIT;
      EMIT:    if (emit_last) state_nxt = SCAN;
      default: state_nxt = SCAN;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    push_code = 5'h00;
    if (state == EMIT && diff != 16'h0) begin
      push      = 1'b1;
      push_code = {candidate[emit_idx], emit_idx};
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      run       <= 1'b0;
      div       <= '0;
      r         <= 2'd0;
      frame     <= '0;
      candidate <= '0;
      stable    <= '0;
      committed <= '0;
    end else begin
      if (!run) begin
        run <= 1'b1;
      end else if (state == SCAN) begin
        if (div == DIV_LAST) begin
          div <= '0;
          r   <= r + 2'd1;
          case (r)
            2'd0:    frame[3:0]  <= ~col_s2;
            2'd1:    frame[7:4]  <= ~col_s2;
            2'd2:    frame[11:8] <= ~col_s2;
            default: ;
          endcase
        end else begin
          div <= div + DW'(1);
        end
      end
      if (frame_end) begin
        candidate <= cand_nxt;
        stable    <= stable_nxt;
      end
      // committed tracks every emitted change even if the FIFO drops it
      if (push) committed[emit_idx] <= candidate[emit_idx];
    end
  end

  assign evt_valid = (evt_count != 6'd0);
  assign pop_ok    = evt_pop && evt_valid;
  assign push_ok   = push && ((evt_count < DEPTH) || pop_ok);
  assign drop      = push && !push_ok;
  assign evt_code  = evt_valid ? mem[rd_ptr] : 5'h00;

  always_ff @(posedge HCLK) begin
    if (push_ok) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= 6'd0;
      overflow  <= 1'b0;
      key_irq   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   evt_count <= evt_count + 6'd1;
        2'b01:   evt_count <= evt_count - 6'd1;
        default: ;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      key_irq <= evt_valid;
    end
  end

endmodule
